// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle between NUM_SRC sources, the round-robin arbiter and one shared sink.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface axis_rr_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int SRC_W = ($clog2(NUM_SRC) < 1) ? 1 : $clog2(NUM_SRC);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_tData;
  logic [NUM_SRC-1:0]            s_tValid;
  logic [NUM_SRC-1:0]            s_tReady;
  logic [DATA_WIDTH-1:0]         m_tData;
  logic                          m_tValid;
  logic                          m_tReady;
  logic [SRC_W-1:0]              m_tSrc;
  logic                          busy;

  modport slave (
    input  s_tData, s_tValid, m_tReady,
    output s_tReady, m_tData, m_tValid, m_tSrc, busy
  );

  modport master (
    output s_tData, s_tValid, m_tReady,
    input  s_tReady, m_tData, m_tValid, m_tSrc, busy
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream arbiter, bursts of up to MAX_BURST beats, one output register.
// Source accept to m_tValid is 1 cycle; sink backpressure stalls the granted source only.
module axis_rr_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  axis_rr_arbiter_if.slave  bus
);
  localparam int SRC_W = ($clog2(NUM_SRC) < 1) ? 1 : $clog2(NUM_SRC);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e                state_q;
  logic [SRC_W-1:0]      rr_ptr_q;
  logic [SRC_W-1:0]      grant_q;
  logic [7:0]            beat_cnt_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_vld_q;
  logic [SRC_W-1:0]      m_src_q;

  logic                  out_free;
  logic                  accept;
  logic                  burst_done;
  logic [NUM_SRC-1:0]    s_rdy;
  logic [SRC_W-1:0]      grant_nxt;
  logic [SRC_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic [SRC_W:0]        cand;

  // Ready depends on registered state and the sink only, never on s_tValid.
  assign out_free = !m_vld_q || bus.m_tReady;

  always_comb begin
    s_rdy = '0;
    if (state_q == GRANT && out_free) begin
      s_rdy[grant_q] = 1'b1;
    end
  end

  assign accept     = |(s_rdy & bus.s_tValid);
  assign burst_done = (beat_cnt_q + 8'd1) == 8'(MAX_BURST);
  assign grant_nxt  = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (cand >= (SRC_W+1)'(NUM_SRC)) begin
        cand = cand - (SRC_W+1)'(NUM_SRC);
      end
      if (!pick_vld && bus.s_tValid[cand[SRC_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_vld_q    <= 1'b0;
      m_src_q    <= '0;
    end else begin
      if (accept) begin
        m_data_q   <= bus.s_tData[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_src_q    <= grant_q;
        m_vld_q    <= 1'b1;
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end else if (bus.m_tReady) begin
        m_vld_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          // A stalled sink keeps the grant; only a full burst or a quiet source releases it.
          if ((accept && burst_done) || !bus.s_tValid[grant_q]) begin
            state_q  <= IDLE;
            rr_ptr_q <= grant_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_tReady = s_rdy;
  assign bus.m_tData  = m_data_q;
  assign bus.m_tValid = m_vld_q;
  assign bus.m_tSrc   = m_src_q;
  assign bus.busy     = (state_q == GRANT) || m_vld_q;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: cycle table, directed corner sequences and random stress
// against per-source ordering, one-hot ready and a bounded-wait fairness rule.
module tb_axis_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int FAIR_BOUND = NS * (MB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  axis_rr_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic          m_rdy;
    logic [NS-1:0] rdy;
    logic          vld;
    logic [1:0]    src;
    logic          busy;
  } vec_t;

  vec_t        tbl [23];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          left [NS];
  logic [31:0] nxt [NS];
  logic [31:0] exp_out [NS];
  int          wait_cnt [NS];
  int          max_wait = 0;
  logic [31:0] out_dat [$];
  int          out_src [$];
  int          out_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      bus.s_tValid[i] = (left[i] > 0);
      bus.s_tData[i*DW +: DW] = nxt[i];
    end
  endtask

  task automatic load_src(input int i, input logic [31:0] base, input int n);
    nxt[i] = base;
    exp_out[i] = base;
    left[i] = n;
    drive();
  endtask

  task automatic add_beats(input int i, input int n);
    left[i] += n;
    drive();
  endtask

  // One clock: observe handshakes mid-cycle, then advance source data after the edge.
  task automatic tick();
    logic [NS-1:0] acc;
    int s;
    @(negedge clk);
    chk("ready_onehot0", 32'($onehot0(bus.s_tReady)), 32'd1);
    acc = bus.s_tValid & bus.s_tReady;
    if (bus.m_tValid && bus.m_tReady) begin
      s = int'(bus.m_tSrc);
      chk("src_order", bus.m_tData, exp_out[s]);
      exp_out[s] = exp_out[s] + 1;
      out_dat.push_back(bus.m_tData);
      out_src.push_back(s);
      out_cyc.push_back(cyc);
      for (int i = 0; i < NS; i++) begin
        if (bus.s_tValid[i] && !acc[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        nxt[i] = nxt[i] + 1;
        left[i]--;
        wait_cnt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      left[i] = 0;
      nxt[i] = '0;
      exp_out[i] = '0;
      wait_cnt[i] = 0;
    end
    max_wait = 0;
    out_dat.delete();
    out_src.delete();
    out_cyc.delete();
    bus.m_tReady = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] hold;
    int exp_seq [8];

    // All four sources requesting continuously, sink always ready.
    tbl[ 0] = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[ 1] = '{1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[ 2] = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[ 3] = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[ 4] = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    tbl[ 5] = '{1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[ 6] = '{1'b1, 4'b0010, 1'b0, 2'd0, 1'b1};
    tbl[ 7] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[ 8] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[ 9] = '{1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 4'b0100, 1'b0, 2'd1, 1'b1};
    tbl[12] = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[13] = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[14] = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
    tbl[15] = '{1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[16] = '{1'b1, 4'b1000, 1'b0, 2'd2, 1'b1};
    tbl[17] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[18] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[19] = '{1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    tbl[20] = '{1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[21] = '{1'b1, 4'b0001, 1'b0, 2'd3, 1'b1};
    tbl[22] = '{1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};

    do_reset();
    chk("reset_m_tData", bus.m_tData, 32'd0);
    for (int i = 0; i < NS; i++) load_src(i, 32'(i) << 24, 100);
    for (int v = 0; v < 23; v++) begin
      bus.m_tReady = tbl[v].m_rdy;
      #0;
      chk($sformatf("tbl%0d_s_tReady", v), 32'(bus.s_tReady), 32'(tbl[v].rdy));
      chk($sformatf("tbl%0d_m_tValid", v), 32'(bus.m_tValid), 32'(tbl[v].vld));
      chk($sformatf("tbl%0d_m_tSrc", v), 32'(bus.m_tSrc), 32'(tbl[v].src));
      chk($sformatf("tbl%0d_busy", v), 32'(bus.busy), 32'(tbl[v].busy));
      tick();
    end

    // Single source, 10 beats: bursts of 4 with one-cycle gaps.
    do_reset();
    load_src(1, 32'hA0, 10);
    n = 0;
    while (out_dat.size() < 10 && n < 60) begin tick(); n++; end
    chk("single_count", 32'(out_dat.size()), 32'd10);
    for (int k = 0; k < out_dat.size() && k < 10; k++) begin
      chk($sformatf("single_dat%0d", k), out_dat[k], 32'hA0 + 32'(k));
      chk($sformatf("single_src%0d", k), 32'(out_src[k]), 32'd1);
      if (k > 0) chk($sformatf("single_gap%0d", k), 32'(out_cyc[k] - out_cyc[k-1]),
                     (k == 4 || k == 8) ? 32'd2 : 32'd1);
    end

    // Backpressure during source 0's burst.
    do_reset();
    load_src(0, 32'hB0, 4);
    n = 0;
    while (!bus.m_tValid && n < 10) begin tick(); n++; end
    chk("bp_setup", 32'(bus.m_tValid), 32'd1);
    bus.m_tReady = 1'b0;
    #0;
    hold = bus.m_tData;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), bus.m_tData, hold);
      chk($sformatf("bp_vld%0d", k), 32'(bus.m_tValid), 32'd1);
      chk($sformatf("bp_rdy%0d", k), 32'(bus.s_tReady), 32'd0);
      chk($sformatf("bp_src%0d", k), 32'(bus.m_tSrc), 32'd0);
      tick();
    end
    bus.m_tReady = 1'b1;
    repeat (12) tick();
    chk("bp_count", 32'(out_dat.size()), 32'd4);
    for (int k = 0; k < out_dat.size() && k < 4; k++)
      chk($sformatf("bp_dat%0d", k), out_dat[k], 32'hB0 + 32'(k));

    // Early release by source 3; the pointer wraps so source 0 is next.
    do_reset();
    load_src(3, 32'h300, 2);
    n = 0;
    while (!bus.s_tReady[3] && n < 10) begin tick(); n++; end
    load_src(0, 32'h100, 4);
    n = 0;
    while (left[3] != 0 && n < 10) begin tick(); n++; end
    tick();
    add_beats(3, 2);
    n = 0;
    while (out_src.size() < 8 && n < 40) begin tick(); n++; end
    exp_seq = '{3, 3, 0, 0, 0, 0, 3, 3};
    chk("early_count", 32'(out_src.size()), 32'd8);
    for (int k = 0; k < out_src.size() && k < 8; k++)
      chk($sformatf("early_src%0d", k), 32'(out_src[k]), 32'(exp_seq[k]));

    // Reset asserted mid-burst with source 2 granted.
    do_reset();
    load_src(2, 32'h200, 10);
    n = 0;
    while (!(bus.m_tValid && bus.m_tSrc == 2'd2) && n < 10) begin tick(); n++; end
    chk("rst_setup", 32'(bus.m_tValid && bus.s_tReady[2]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_m_tValid", 32'(bus.m_tValid), 32'd0);
    chk("rst_s_tReady", 32'(bus.s_tReady), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_m_tSrc", 32'(bus.m_tSrc), 32'd0);
    do_reset();
    load_src(3, 32'h330, 2);
    load_src(1, 32'h110, 2);
    n = 0;
    while (out_src.size() == 0 && n < 10) begin tick(); n++; end
    chk("rst_first_grant", (out_src.size() > 0) ? 32'(out_src[0]) : 32'hFFFF_FFFF, 32'd1);

    // Random stress with legal sources (valid held until accepted).
    do_reset();
    for (int i = 0; i < NS; i++) load_src(i, 32'(i) << 24, 0);
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NS; i++)
        if (left[i] == 0 && $urandom_range(0, 2) == 0) left[i] = $urandom_range(1, 6);
      bus.m_tReady = ($urandom_range(0, 3) != 0);
      drive();
      tick();
    end
    bus.m_tReady = 1'b1;
    n = 0;
    while ((left[0] + left[1] + left[2] + left[3]) != 0 && n < 500) begin tick(); n++; end
    repeat (3) tick();
    for (int i = 0; i < NS; i++)
      chk($sformatf("rand_drain_src%0d", i), exp_out[i], nxt[i]);
    chk("rand_idle_vld", 32'(bus.m_tValid), 32'd0);
    chk("rand_fair_wait", 32'(max_wait <= FAIR_BOUND), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Stream basic sink among NUM_SRC AXI4-Stream basic sources.
- Grants one source at a time and holds the grant for a burst of up to MAX_BURST beats.
- Drives the sink through a single output register stage and tags each output beat with its source index.
- Sits in front of any shared stream consumer: DMA engine, AXI4-Lite bridge command queue or shared FIFO.

Parameters:
- NUM_SRC, 4: number of source ports; range 2..16.
- DATA_WIDTH, 32: tData width in bits, per source and on the output.
- MAX_BURST, 4: maximum beats accepted per grant before forced rotation; range 1..255.
- Derived SRC_W = max(1, $clog2(NUM_SRC)).

Ports:
- clk  in  1  single clock; all state is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tData  in  NUM_SRC*DATA_WIDTH  source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_tValid  in  NUM_SRC  per-source valid.
- s_tReady  out  NUM_SRC  per-source ready; at most one bit set.
- m_tData  out  DATA_WIDTH  registered output data.
- m_tValid  out  1  registered output valid.
- m_tReady  in  1  sink ready.
- m_tSrc  out  SRC_W  index of the source that produced the current m_tData.
- busy  out  1  high while in GRANT or while m_tValid is high.

Behaviour:
- Reset (asynchronous assert, synchronous use after release):
  - state = IDLE; rr_ptr = 0; grant = 0; beat_cnt = 0.
  - m_tValid = 0; m_tData = 0; m_tSrc = 0; s_tReady = 0; busy = 0.
  - Reset asserted mid-burst discards the in-flight output beat; no partial-state recovery.
- Handshake:
  - A beat transfers on s_tValid[i] & s_tReady[i], and on m_tValid & m_tReady.
  - Sources must hold tData/tValid until accepted.
  - Once m_tValid is asserted, m_tData and m_tSrc stay stable until m_tReady.
- Ready rule (combinational from registered state):
  - s_tReady[i] = (state == GRANT) & (grant == i) & (!m_tValid | m_tReady).
  - No combinational path from any s_tValid to any s_tReady.
- State machine, IDLE:
  - If any s_tValid is high, pick the first requesting index searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_SRC.
  - Register it into grant, clear beat_cnt, go to GRANT.
  - Arbitration costs one bubble cycle; s_tReady is 0 in IDLE.
- State machine, GRANT:
  - On each accepted beat: m_tData <= beat, m_tSrc <= grant, m_tValid <= 1, beat_cnt++.
  - If the accept makes beat_cnt == MAX_BURST: go to IDLE, rr_ptr <= (grant + 1) mod NUM_SRC.
  - Else if s_tValid[grant] == 0 in a cycle with no accept: go to IDLE, rr_ptr <= (grant + 1) mod NUM_SRC.
  - Sink backpressure (m_tValid & !m_tReady) does not count as a release; the grant is held.
- Output register:
  - m_tValid clears when m_tReady is high and no new beat is accepted that cycle.
  - Latency from source accept to m_tValid: 1 cycle.
  - Sustained throughput is 1 beat/cycle within a burst, with a 1-cycle gap between grants.
- Simultaneous events: an accept and an output drain in the same cycle are legal; the register reloads and m_tValid stays 1.
- beat_cnt is 8 bits wide and never exceeds MAX_BURST.
- Wrap-around: rr_ptr at NUM_SRC-1 rotates to 0.
- Fairness: every persistently requesting source is granted within NUM_SRC grants.

Test Plan:
- Reset values: assert rst mid-burst with source 2 granted and m_tValid = 1 -> the same cycle shows m_tValid = 0, s_tReady = 0, busy = 0; after release, the first grant goes to the lowest requesting index ≥ 0.
- Single source: only source 1 is valid with data 0xA0..0xA9 (10 beats), MAX_BURST = 4, m_tReady = 1 -> output sequence 0xA0..0xA9, all with m_tSrc = 1, and a 1-cycle gap after beats 4 and 8.
- All four sources valid continuously, MAX_BURST = 4 -> grant order 0, 1, 2, 3, 0; each grant yields exactly 4 beats with the matching m_tSrc.
- Backpressure: hold m_tReady = 0 for 5 cycles during source 0's burst -> m_tData is stable, s_tReady[0] = 0, no grant change; after release the burst completes with 4 beats total and no loss or duplication.
- Early release: source 3 drops s_tValid after 2 beats while source 0 is valid -> next grant is 0 (wrap from rr_ptr = 0 after 3); source 3 is not re-granted before source 0.
- Random stress: random s_tValid and m_tReady over 10k cycles -> a scoreboard matches per-source ordering, at most one s_tReady bit is ever set, and no source waits more than NUM_SRC*(MAX_BURST+1) output beats.
